// File: rtl/serv_mem_arbiter.sv
// serv_mem_arbiter: shares one memory port between serv's ibus and dbus with dbus priority and an ibus starvation guard.
// Optional forced completion of stalled grants is enabled by defining SERV_ARB_TIMEOUT_EN.
module serv_mem_arbiter #(
   parameter int MAX_DBUS_RUN   = 4,
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic        clk,
   input  logic        i_rst,
   input  logic [31:0] i_ibus_adr,
   input  logic        i_ibus_cyc,
   output logic [31:0] o_ibus_rdt,
   output logic        o_ibus_ack,
   input  logic [31:0] i_dbus_adr,
   input  logic [31:0] i_dbus_dat,
   input  logic [3:0]  i_dbus_sel,
   input  logic        i_dbus_we,
   input  logic        i_dbus_cyc,
   output logic [31:0] o_dbus_rdt,
   output logic        o_dbus_ack,
   output logic [31:0] o_mem_adr,
   output logic [31:0] o_mem_dat,
   output logic [3:0]  o_mem_sel,
   output logic        o_mem_we,
   output logic        o_mem_cyc,
   input  logic [31:0] i_mem_rdt,
   input  logic        i_mem_ack,
   output logic        o_timeout
);
   if (MAX_DBUS_RUN < 1 || MAX_DBUS_RUN > 15 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_param
      $error("serv_mem_arbiter: parameter out of range");
   end
   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
   state_t state_d, state_q;
   logic [3:0] run_cnt_d, run_cnt_q;
   logic gnt_i, gnt_d, cyc, tmo, done, take_d;
   assign gnt_i = state_q == GNT_I;
   assign gnt_d = state_q == GNT_D;
   assign cyc = (gnt_i & i_ibus_cyc) | (gnt_d & i_dbus_cyc);
`ifdef SERV_ARB_TIMEOUT_EN
   logic [7:0] tmo_cnt_q;
   assign tmo = cyc & ~i_mem_ack & ~i_rst & (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));
   always_ff @(posedge clk)
      tmo_cnt_q <= (i_rst || state_q == IDLE) ? 8'd0 : tmo_cnt_q + {7'd0, ~i_mem_ack};
`else
   assign tmo = 1'b0;
`endif
   assign done       = cyc & ~i_rst & (i_mem_ack | tmo);
   assign o_ibus_ack = gnt_i & done;
   assign o_dbus_ack = gnt_d & done;
   assign o_timeout  = tmo;
   assign o_ibus_rdt = tmo ? 32'd0 : i_mem_rdt;
   assign o_dbus_rdt = tmo ? 32'd0 : i_mem_rdt;
   assign o_mem_cyc  = cyc;
   assign o_mem_adr  = gnt_d ? i_dbus_adr : gnt_i ? i_ibus_adr : 32'd0;
   assign o_mem_dat  = gnt_d ? i_dbus_dat : 32'd0;
   assign o_mem_sel  = gnt_d ? i_dbus_sel : gnt_i ? 4'hF : 4'h0;
   assign o_mem_we   = gnt_d & i_dbus_we;
   // dbus loses priority only once it has won MAX_DBUS_RUN times in a row over a waiting ibus
   assign take_d = i_dbus_cyc & ~(i_ibus_cyc & (run_cnt_q == 4'(MAX_DBUS_RUN)));
   always_comb begin
      state_d   = state_q;
      run_cnt_d = run_cnt_q;
      if (state_q == IDLE) begin
         if (take_d) begin
            state_d   = GNT_D;
            run_cnt_d = !i_ibus_cyc ? 4'd0 : (run_cnt_q == 4'(MAX_DBUS_RUN)) ? run_cnt_q : run_cnt_q + 4'd1;
         end else if (i_ibus_cyc) begin
            state_d   = GNT_I;
            run_cnt_d = 4'd0;
         end
      end else if (!cyc || done) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         run_cnt_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         run_cnt_q <= run_cnt_d;
      end
   end
endmodule
